// File: rtl/f32_mult_dispatch.sv
// -----------------------------------------------------------------------------
// f32_mult_dispatch
//
// Operand-side front end for a start/done f32 multiplier core. Operand pairs
// arrive on a valid/ready stream and are queued in a small FIFO. One product at
// a time is issued to the core with a single-cycle start pulse, and the operands
// are held until the core reports done. Each product lands in a valid/ready
// output register with IEEE class flags. A watchdog bounds the wait for done and
// substitutes a quiet NaN flagged as a timeout.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_in_valid/o_in_ready  operand stream handshake (o_in_ready = !full)
//   i_in_a, i_in_b       operands (f32)
//   o_out_valid/i_out_ready result stream handshake
//   o_out_p              product (f32)
//   o_out_flags          {timeout, nan, inf, zero}
//   o_mul_start          one-cycle start pulse to the core
//   o_mul_a, o_mul_b     registered operands to the core
//   i_mul_done, i_mul_p  core done pulse and product
//   o_busy               FSM not idle or FIFO non-empty
//   o_count              FIFO occupancy
// -----------------------------------------------------------------------------
module f32_mult_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [31:0]                  i_in_a,
  input  logic [31:0]                  i_in_b,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [31:0]                  o_out_p,
  output logic [3:0]                   o_out_flags,
  output logic                         o_mul_start,
  output logic [31:0]                  o_mul_a,
  output logic [31:0]                  o_mul_b,
  input  logic                         i_mul_done,
  input  logic [31:0]                  i_mul_p,
  output logic                         o_busy,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  // Control state
  logic [1:0]    r_state;
  logic [TW-1:0] r_wdog;
  logic          r_live;      // holds in_ready low while in reset
  logic [31:0]   r_mul_a;
  logic [31:0]   r_mul_b;
  logic          r_mul_start;
  logic          r_out_valid;
  logic [31:0]   r_out_p;
  logic [3:0]    r_out_flags;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_slot_free;
  logic          w_capture;
  logic          w_wdog_hit;
  logic          w_wdog_fire;
  logic [63:0]   w_head;
  logic [7:0]    w_exp;
  logic [22:0]   w_man;
  logic [2:0]    w_class;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_in_ready  = r_live && !w_full;
  assign w_push      = i_in_valid && o_in_ready;

  // The slot can take a new result if it is empty or being drained this cycle.
  // Popping only when the slot is free guarantees it is empty by capture time.
  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_pop       = (r_state == S_IDLE) && !w_empty && w_slot_free;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

  assign w_capture   = (r_state == S_WAIT) && i_mul_done;
  assign w_wdog_hit  = (r_wdog == TW'(TIMEOUT - 1));
  assign w_wdog_fire = (r_state == S_WAIT) && !i_mul_done && w_wdog_hit;

  // Class of the core product; denormals are flushed by the core, so exp==0
  // always means zero.
  assign w_exp   = i_mul_p[30:23];
  assign w_man   = i_mul_p[22:0];
  assign w_class = {(&w_exp) && (|w_man),     // nan
                    (&w_exp) && !(|w_man),    // inf
                    !(|w_exp)};               // zero

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_in_a, i_in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM and watchdog
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wdog      <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_mul_a     <= w_head[63:32];
            r_mul_b     <= w_head[31:0];
            r_mul_start <= 1'b1;         // high exactly during ISSUE
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mul_done) begin
            r_state <= S_IDLE;
          end else if (w_wdog_hit) begin
            r_wdog  <= '0;
            r_state <= S_RECOVER;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
        end
        default: begin
          // Absorb a late done from the timed-out op so it cannot be
          // mistaken for the result of the next op.
          if (i_mul_done || w_wdog_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_out_flags <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_p     <= i_mul_p;
      r_out_flags <= {1'b0, w_class};
    end else if (w_wdog_fire) begin
      r_out_valid <= 1'b1;
      r_out_p     <= QNAN;
      r_out_flags <= 4'b1000;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_p     = r_out_p;
  assign o_out_flags = r_out_flags;
  assign o_mul_start = r_mul_start;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;
  assign o_count     = CW'(r_wr_ptr - r_rd_ptr);

endmodule

// File: tb/tb_f32_mult_dispatch.sv
// -----------------------------------------------------------------------------
// tb_f32_mult_dispatch
//
// Directed testbench for f32_mult_dispatch. A small core stub answers the
// start pulse with a hand-tabulated product after 4 cycles (normal operands)
// or 3 cycles (zero/inf/NaN/denormal operands), or never when hung. A late or
// stray done can be injected by hand.
// -----------------------------------------------------------------------------
module tb_f32_mult_dispatch;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_in_a = '0;
  logic [31:0] i_in_b = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_out_p;
  logic [3:0]  o_out_flags;
  logic        o_mul_start;
  logic [31:0] o_mul_a;
  logic [31:0] o_mul_b;
  logic        i_mul_done;
  logic [31:0] i_mul_p;
  logic        o_busy;
  logic [2:0]  o_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int push_cyc = 0;

  f32_mult_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_a      (i_in_a),
    .i_in_b      (i_in_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_p     (o_out_p),
    .o_out_flags (o_out_flags),
    .o_mul_start (o_mul_start),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .i_mul_done  (i_mul_done),
    .i_mul_p     (i_mul_p),
    .o_busy      (o_busy),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- core stub ----------------
  logic [2:0]  stub_cnt;
  logic [31:0] stub_p;
  logic        stub_hang = 1'b0;
  logic        inject = 1'b0;

  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] core_product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, b};
    case (ab)
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h7FC00001, 32'h3F800000}: return 32'h7FC00000;
      {32'h7F800000, 32'h00000000}: return 32'h7FC00000;
      {32'hBF800000, 32'h7F800000}: return 32'hFF800000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= 3'd0;
      stub_p   <= 32'd0;
    end else if (o_mul_start) begin
      stub_cnt <= stub_hang ? 3'd0
                : ((is_special(o_mul_a) || is_special(o_mul_b)) ? 3'd3 : 3'd4);
      stub_p   <= core_product(o_mul_a, o_mul_b);
    end else if (stub_cnt != 3'd0) begin
      stub_cnt <= stub_cnt - 3'd1;
    end
  end

  assign i_mul_done = (stub_cnt == 3'd1) || inject;
  assign i_mul_p    = inject ? 32'h12345678 : stub_p;

  // ---------------- drive helpers (start and end just after a negedge) -----
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (o_in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (o_in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", o_in_ready, n);
    end
    i_in_valid = 1'b1;
    i_in_a     = a;
    i_in_b     = b;
    push_cyc   = cyc;
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] p, output logic [3:0] f, output int at);
    int n = 0;
    while (o_out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", o_out_valid, n);
      p  = 'x;
      f  = 'x;
      at = -1;
    end else begin
      p  = o_out_p;
      f  = o_out_flags;
      at = cyc;
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if ({o_out_valid, o_out_p, o_out_flags, o_mul_start, o_mul_a, o_mul_b,
         o_busy, o_in_ready, o_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b p=%h flags=%b start=%b a=%h b=%h busy=%b in_ready=%b count=%0d, required all 0",
               o_out_valid, o_out_p, o_out_flags, o_mul_start, o_mul_a, o_mul_b, o_busy, o_in_ready, o_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1 || o_count !== 3'd0 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b count=%0d busy=%b valid=%b, required 1/0/0/0",
               o_in_ready, o_count, o_busy, o_out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int start_cnt = 0;
    int start_at = -1;
    int valid_at = -1;
    int opnd_bad = 0;
    logic [31:0] p = '0;
    logic [3:0]  f = '0;
    i_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (o_mul_start === 1'b1) begin
        start_cnt++;
        if (start_at < 0) start_at = c;
      end
      if (o_out_valid === 1'b1 && valid_at < 0) begin
        valid_at = c;
        p = o_out_p;
        f = o_out_flags;
      end
      if (c >= 2 && c <= 6 && (o_mul_a !== 32'h40000000 || o_mul_b !== 32'h40400000)) opnd_bad++;
      i_in_valid = (c == 0);
      i_in_a     = 32'h40000000;
      i_in_b     = 32'h40400000;
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    checks++;
    if (start_at != 2 || start_cnt != 1) begin
      failures++;
      $display("FAIL basic_start: first at cycle %0d, %0d pulses; required cycle 2, 1 pulse", start_at, start_cnt);
    end
    checks++;
    if (valid_at != 7) begin
      failures++;
      $display("FAIL basic_latency: out_valid first at cycle %0d, required 7", valid_at);
    end
    checks++;
    if (p !== 32'h40C00000 || f !== 4'b0000) begin
      failures++;
      $display("FAIL basic_result: p=%h flags=%b, required 40c00000/0000", p, f);
    end
    checks++;
    if (opnd_bad != 0) begin
      failures++;
      $display("FAIL basic_operands: %0d cycles with unstable mul_a/mul_b, required 0", opnd_bad);
    end
    $display("test_basic: p=%h flags=%b start@%0d valid@%0d", p, f, start_at, valid_at);
  endtask

  task automatic test_special();
    logic [31:0] p;
    logic [3:0]  f;
    int at;
    int p0;
    i_out_ready = 1'b1;
    push(32'h7FC00001, 32'h3F800000);
    p0 = push_cyc;
    push(32'h7F800000, 32'h00000000);
    push(32'hBF800000, 32'h7F800000);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'h7FC00000 || f !== 4'b0100 || at - p0 != 6) begin
      failures++;
      $display("FAIL special_nan: p=%h flags=%b latency=%0d, required 7fc00000/0100/6", p, f, at - p0);
    end
    $display("test_special nan: p=%h flags=%b", p, f);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'h7FC00000 || f !== 4'b0100) begin
      failures++;
      $display("FAIL special_inf_x_zero: p=%h flags=%b, required 7fc00000/0100", p, f);
    end
    $display("test_special inf*0: p=%h flags=%b", p, f);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'hFF800000 || f !== 4'b0010) begin
      failures++;
      $display("FAIL special_neg_inf: p=%h flags=%b, required ff800000/0010", p, f);
    end
    $display("test_special -1*inf: p=%h flags=%b", p, f);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    int n = 0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_p = '0;
    logic [31:0] held;
    i_out_ready = 1'b0;
    i_in_a = 32'h3F800000;
    i_in_b = 32'h3F800000;
    for (int c = 0; c < 20; c++) begin
      i_in_valid = (acc < 6);
      if (i_in_valid && o_in_ready) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc != 5 || o_count !== 3'd4 || o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_out_p !== 32'h3F800000) begin
      failures++;
      $display("FAIL bp_full: accepted=%0d count=%0d in_ready=%b valid=%b p=%h, required 5/4/0/1/3f800000",
               acc, o_count, o_in_ready, o_out_valid, o_out_p);
    end
    held = o_out_p;
    repeat (3) @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_p !== held || o_count !== 3'd4) begin
      failures++;
      $display("FAIL bp_hold: valid=%b p=%h count=%0d, required 1/%h/4", o_out_valid, o_out_p, o_count, held);
    end
    i_in_valid = 1'b0;
    while (got < 5 && n < 300) begin
      if (prev_hold) begin
        checks++;
        if (o_out_valid !== 1'b1 || o_out_p !== prev_p) begin
          failures++;
          $display("FAIL bp_stable: valid=%b p=%h, required 1/%h", o_out_valid, o_out_p, prev_p);
        end
      end
      i_out_ready = (n % 3 != 2);
      if (o_out_valid === 1'b1 && i_out_ready) begin
        got++;
        checks++;
        if (o_out_p !== 32'h3F800000 || o_out_flags !== 4'b0000) begin
          failures++;
          $display("FAIL bp_result: p=%h flags=%b, required 3f800000/0000", o_out_p, o_out_flags);
        end
        $display("test_backpressure result %0d: p=%h flags=%b", got, o_out_p, o_out_flags);
      end
      prev_hold = (o_out_valid === 1'b1) && !i_out_ready;
      prev_p    = o_out_p;
      @(negedge clk);
      n++;
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (got != 5 || o_count !== 3'd0 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: results=%0d count=%0d busy=%b valid=%b, required 5/0/0/0", got, o_count, o_busy, o_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    logic [3:0]  f;
    int at;
    int n = 0;
    i_out_ready = 1'b0;
    push(32'h40000000, 32'h40400000);
    while (o_out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    push(32'h3F800000, 32'h3F800000);
    @(negedge clk);
    checks++;
    if (o_count !== 3'd1 || o_out_valid !== 1'b1 || o_out_p !== 32'h40C00000) begin
      failures++;
      $display("FAIL b2b_setup: count=%0d valid=%b p=%h, required 1/1/40c00000", o_count, o_out_valid, o_out_p);
    end
    // consume the held result, push a new pair and let the FSM pop, all at once
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_in_a      = 32'hBF800000;
    i_in_b      = 32'h7F800000;
    @(negedge clk);
    i_in_valid = 1'b0;
    checks++;
    if (o_count !== 3'd1 || o_mul_start !== 1'b1 || o_out_valid !== 1'b0 || o_mul_a !== 32'h3F800000) begin
      failures++;
      $display("FAIL b2b_simultaneous: count=%0d start=%b valid=%b mul_a=%h, required 1/1/0/3f800000",
               o_count, o_mul_start, o_out_valid, o_mul_a);
    end
    wait_result(p, f, at);
    checks++;
    if (p !== 32'h3F800000 || f !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_first: p=%h flags=%b, required 3f800000/0000", p, f);
    end
    $display("test_back_to_back first: p=%h flags=%b", p, f);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'hFF800000 || f !== 4'b0010) begin
      failures++;
      $display("FAIL b2b_second: p=%h flags=%b, required ff800000/0010", p, f);
    end
    $display("test_back_to_back second: p=%h flags=%b", p, f);
  endtask

  task automatic test_watchdog();
    logic [31:0] p;
    logic [3:0]  f;
    int at;
    i_out_ready = 1'b1;
    stub_hang   = 1'b1;
    push(32'h40000000, 32'h40400000);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'h7FC00000 || f !== 4'b1000 || at - push_cyc != 18) begin
      failures++;
      $display("FAIL wdog_result: p=%h flags=%b latency=%0d, required 7fc00000/1000/18", p, f, at - push_cyc);
    end
    $display("test_watchdog timeout: p=%h flags=%b", p, f);
    // late done while recovering must be dropped
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL wdog_late_done: valid=%b busy=%b, required 0/0", o_out_valid, o_busy);
    end
    // stray done while idle must be ignored
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_stray_done: valid=%b, required 0", o_out_valid);
    end
    stub_hang = 1'b0;
    push(32'h3F800000, 32'h3F800000);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'h3F800000 || f !== 4'b0000 || at - push_cyc != 7) begin
      failures++;
      $display("FAIL wdog_next_op: p=%h flags=%b latency=%0d, required 3f800000/0000/7", p, f, at - push_cyc);
    end
    $display("test_watchdog next op: p=%h flags=%b", p, f);
  endtask

  task automatic test_async_reset();
    logic [31:0] p;
    logic [3:0]  f;
    int at;
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h40000000, 32'h40400000);
    checks++;
    if (o_count !== 3'd3 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: count=%0d busy=%b, required 3/1", o_count, o_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_out_valid, o_out_p, o_out_flags, o_mul_start, o_mul_a, o_mul_b,
         o_busy, o_in_ready, o_count} !== '0) begin
      failures++;
      $display("FAIL arst_outputs: valid=%b p=%h flags=%b start=%b a=%h busy=%b in_ready=%b count=%0d, required all 0",
               o_out_valid, o_out_p, o_out_flags, o_mul_start, o_mul_a, o_busy, o_in_ready, o_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(32'h40000000, 32'h40400000);
    wait_result(p, f, at);
    checks++;
    if (p !== 32'h40C00000 || f !== 4'b0000 || at - push_cyc != 7) begin
      failures++;
      $display("FAIL arst_after: p=%h flags=%b latency=%0d, required 40c00000/0000/7", p, f, at - push_cyc);
    end
    $display("test_async_reset after release: p=%h flags=%b", p, f);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule
